// File: rtl/id_stage.sv
// id_stage: RV32I instruction decode stage sitting directly upstream of reg_file.
//
// Accepts a fetched instruction and its PC over a valid/ready handshake. It
// drives the reg_file read addresses combinationally from the incoming word,
// captures the operands and decodes the immediate, rd write enable and the
// illegal-opcode flag. The result goes into one output register for execute.
//
// Build option:
//   ID_BYPASS_EN  - when defined, a write-back in the accept cycle is forwarded
//                   into the captured operands, and a write-back to a stalled
//                   held bundle refreshes its operands. When undefined, the
//                   operands are the raw reg_file data (x0 still reads as 0),
//                   and the surrounding pipeline must insert a bubble after a
//                   write-back conflict.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   in_valid/in_ready         fetch handshake
//   in_instr, in_pc           incoming instruction word and address
//   flush                     kill held and incoming instruction
//   rf_a1, rf_a2              reg_file read addresses (combinational)
//   rf_rd1, rf_rd2            reg_file read data (combinational)
//   wb_we, wb_a3, wb_wd       write-back port shared with reg_file
//   out_valid/out_ready       execute handshake
//   out_pc, out_instr         held instruction address and word
//   out_rs1_val, out_rs2_val  operand values
//   out_imm                   sign-extended immediate
//   out_rs1, out_rs2, out_rd  register fields
//   out_reg_we                instruction writes a nonzero rd
//   out_illegal               opcode outside the supported set
//
// state | meaning
// ------+------------------------------------------
// EMPTY | no decoded bundle held, out_valid = 0
// FULL  | decoded bundle held for execute, out_valid = 1

module id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic [4:0]  rf_a1,
   output logic [4:0]  rf_a2,
   input  logic [31:0] rf_rd1,
   input  logic [31:0] rf_rd2,
   input  logic        wb_we,
   input  logic [4:0]  wb_a3,
   input  logic [31:0] wb_wd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [31:0] out_rs1_val,
   output logic [31:0] out_rs2_val,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic        out_reg_we,
   output logic        out_illegal
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t state, state_nxt;

   logic        accept;
   logic [6:0]  opcode;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic [31:0] dec_imm;
   logic        dec_we_class;
   logic        dec_illegal;
   logic [31:0] op1, op2;
   logic        hold;

   assign out_valid = (state == FULL);
   assign in_ready  = !flush && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign hold      = out_valid && !out_ready;

   assign opcode  = in_instr[6:0];
   assign dec_rs1 = in_instr[19:15];
   assign dec_rs2 = in_instr[24:20];
   assign dec_rd  = in_instr[11:7];
   assign rf_a1   = dec_rs1;
   assign rf_a2   = dec_rs2;

   always_comb begin
      dec_imm      = 32'b0;
      dec_we_class = 1'b0;
      dec_illegal  = 1'b0;
      unique case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
            dec_imm      = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_we_class = 1'b1;
         end
         OPC_STORE:
            dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         OPC_BRANCH:
            dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: begin
            dec_imm      = {in_instr[31:12], 12'b0};
            dec_we_class = 1'b1;
         end
         OPC_JAL: begin
            dec_imm      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            dec_we_class = 1'b1;
         end
         OPC_OP:
            dec_we_class = 1'b1;
         default:
            dec_illegal = 1'b1;
      endcase
   end

   // reg_file does not hard-wire x0, so it is forced to zero here.
`ifdef ID_BYPASS_EN
   always_comb begin
      op1 = rf_rd1;
      op2 = rf_rd2;
      if (wb_we && (wb_a3 == dec_rs1)) op1 = wb_wd;
      if (wb_we && (wb_a3 == dec_rs2)) op2 = wb_wd;
      if (dec_rs1 == 5'd0) op1 = 32'b0;
      if (dec_rs2 == 5'd0) op2 = 32'b0;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_we, wb_a3, wb_wd};
   assign op1 = (dec_rs1 == 5'd0) ? 32'b0 : rf_rd1;
   assign op2 = (dec_rs2 == 5'd0) ? 32'b0 : rf_rd2;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= EMPTY;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush)                         state_nxt = EMPTY;
      else if (accept)                   state_nxt = FULL;
      else if (state == FULL && out_ready) state_nxt = EMPTY;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_pc      <= 32'b0;
         out_instr   <= NOP_INSTR;
         out_rs1_val <= 32'b0;
         out_rs2_val <= 32'b0;
         out_imm     <= 32'b0;
         out_rs1     <= 5'b0;
         out_rs2     <= 5'b0;
         out_rd      <= 5'b0;
         out_reg_we  <= 1'b0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_pc      <= 32'b0;
         out_instr   <= NOP_INSTR;
         out_rs1_val <= 32'b0;
         out_rs2_val <= 32'b0;
         out_imm     <= 32'b0;
         out_rs1     <= 5'b0;
         out_rs2     <= 5'b0;
         out_rd      <= 5'b0;
         out_reg_we  <= 1'b0;
         out_illegal <= 1'b0;
      end else if (accept) begin
         out_pc      <= in_pc;
         out_instr   <= in_instr;
         out_rs1_val <= op1;
         out_rs2_val <= op2;
         out_imm     <= dec_imm;
         out_rs1     <= dec_rs1;
         out_rs2     <= dec_rs2;
         out_rd      <= dec_rd;
         out_reg_we  <= dec_we_class && (dec_rd != 5'd0);
         out_illegal <= dec_illegal;
      end
`ifdef ID_BYPASS_EN
      else if (hold && wb_we) begin
         // A stalled bundle would otherwise miss a result retired under it.
         if ((wb_a3 == out_rs1) && (out_rs1 != 5'd0)) out_rs1_val <= wb_wd;
         if ((wb_a3 == out_rs2) && (out_rs2 != 5'd0)) out_rs2_val <= wb_wd;
      end
`endif
   end

`ifndef ID_BYPASS_EN
   logic unused_hold;
   assign unused_hold = hold;
`endif

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage placed directly upstream of `reg_file`. It accepts a fetched RV32I instruction and its PC over a valid/ready handshake, and drives the register-file read addresses. It bypasses same-cycle write-back data and decodes the immediate and control fields. The decoded bundle is held in a single output pipeline register feeding the execute stage.

## Interface
- `NOP_INSTR`, default 32'h00000013: instruction word substituted into `out_instr` on reset/flush.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: fetch presents an instruction.
- `in_ready`, out, 1: stage accepts this cycle.
- `in_instr`, in, 32: instruction word.
- `in_pc`, in, 32: instruction address.
- `flush`, in, 1: kill the held and incoming instruction.
- `rf_a1`, out, 5: reg_file read address 1, equal to `in_instr[19:15]`.
- `rf_a2`, out, 5: reg_file read address 2, equal to `in_instr[24:20]`.
- `rf_rd1`, in, 32: reg_file read data 1 (combinational).
- `rf_rd2`, in, 32: reg_file read data 2 (combinational).
- `wb_we`, in, 1: write-back enable, same net as reg_file `WE3`.
- `wb_a3`, in, 5: write-back address, same net as `A3`.
- `wb_wd`, in, 32: write-back data, same net as `WD3`.
- `out_valid`, out, 1: decoded bundle valid.
- `out_ready`, in, 1: execute stage consumes the bundle.
- `out_pc`, out, 32: PC of the held instruction.
- `out_instr`, out, 32: held instruction word.
- `out_rs1_val`, out, 32: operand 1.
- `out_rs2_val`, out, 32: operand 2.
- `out_imm`, out, 32: sign-extended immediate.
- `out_rs1`, out, 5: source register 1 field.
- `out_rs2`, out, 5: source register 2 field.
- `out_rd`, out, 5: destination register field.
- `out_reg_we`, out, 1: instruction writes `rd`.
- `out_illegal`, out, 1: opcode is not in the supported set.

## Operation
- Handshake and accept:
  - `in_ready = !flush && (!out_valid || out_ready)`.
  - Accept occurs when `in_valid && in_ready`.
- Operand capture on accept:
  - If `rs` is 0, the operand value is 0. `reg_file` does not hard-wire x0.
  - Else, if `wb_we` is set and `wb_a3 == rs`, the operand value is `wb_wd`.
  - Else, the operand value is `rf_rd1`/`rf_rd2`.
- Held-operand refresh: while `out_valid && !out_ready`, a write-back with `wb_we`, `wb_a3 == out_rs1` and `out_rs1 != 0` overwrites `out_rs1_val` with `wb_wd`. The same rule applies to rs2.
- Immediate by opcode:
  - I-type (0000011, 0010011, 1100111): `{{20{i[31]}},i[31:20]}`.
  - S-type (0100011): `{{20{i[31]}},i[31:25],i[11:7]}`.
  - B-type (1100011): `{{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}`.
  - U-type (0110111, 0010111): `{i[31:12],12'b0}`.
  - J-type (1101111): `{{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}`.
  - R-type (0110011) and illegal opcodes: 0.
- Destination write enable: `out_reg_we = 1` for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP when `rd != 0`. It is 0 otherwise.
- Illegal instruction: any other opcode sets `out_illegal = 1` and forces `out_reg_we = 0`. The instruction still passes with `out_valid`.
- Register states: EMPTY (`out_valid = 0`) and FULL (`out_valid = 1`).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with `out_ready`.
  - FULL→EMPTY on `out_ready` with no accept.
  - Any state→EMPTY on `flush`.

## Timing
- Reset values: `out_valid = 0`, `out_instr = NOP_INSTR`, all other outputs 0. `in_ready` reads 1 out of reset.
- Latency: 1 cycle from accept edge to `out_valid`.
- Throughput: 1 instruction per cycle while `out_ready` stays high.
- `rf_a1`/`rf_a2` are combinational from `in_instr` and ungated.
- Flush:
  - Takes effect at the next edge: `out_valid = 0` and `out_instr = NOP_INSTR`.
  - The incoming instruction in the flush cycle is not accepted.
  - Flush overrides both refresh and accept.
- Write-back coincident with accept is bypassed. Write-back one cycle earlier is already visible in reg_file.
- Reset mid-stall clears the held bundle immediately; no partial output.

## Configuration
- `ID_BYPASS_EN` defined:
  - Write-back bypass on accept is active.
  - Held-operand refresh is active.
- `ID_BYPASS_EN` undefined:
  - Operands are the raw `rf_rd*` values, with rs 0 still forced to 0.
  - No refresh occurs.
  - The surrounding pipeline must insert one bubble after write-back conflicts.

## Test plan
- Reset, then accept `addi x5,x0,-3` (32'hFFD00293) -> next cycle: `out_valid = 1`, `out_imm = 32'hFFFFFFFD`, `out_rd = 5`, `out_reg_we = 1`, `out_rs1_val = 0`.
- Accept `add x3,x1,x2` (32'h002081B3) while `wb_we = 1`, `wb_a3 = 1`, `wb_wd = 32'h1234`, `rf_rd1 = 0` -> `out_rs1_val = 32'h1234` with bypass enabled, 0 without.
- Hold `out_ready = 0` with `sw x2,8(x1)` (32'h0020A423) held, then write x2 = 32'hCAFE -> `out_rs2_val = 32'hCAFE`, `out_imm = 8`, `out_reg_we = 0`, `in_ready = 0`.
- Accept instruction 32'h0000007F -> `out_illegal = 1`, `out_reg_we = 0`, `out_valid = 1`.
- Assert `flush` in a cycle with `in_valid = 1` and a FULL stage -> next cycle `out_valid = 0`, `out_instr = 32'h00000013`; the incoming instruction is dropped.
- Back-to-back stream of 4 instructions with `out_ready = 1`, with `out_ready` low for 2 cycles mid-stream -> all 4 delivered in order, none duplicated or lost.
